multicycle_ctrl: RTL

Multi-cycle sequencer for the RV32 core that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It issues instruction- and data-memory request handshakes and drives the datapath enables (br, memreg, mr, mw, alusrc, regwr, aluop) per state from a latched opcode. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32 sequencer.
// Each instruction steps through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// The block issues the instruction and data memory requests, drives the
// datapath enables for each state from the latched opcode, counts retired
// instructions, and traps on illegal opcodes or memory timeouts.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   permits starting a new instruction (level)
//   opcode[6:0]           instr[6:0], latched while ir_we=1
//   zero                  ALU zero flag, used for branches in EXEC
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, dmem_req    memory requests
//   ir_we, pc_we, pc_src  IR load, PC update, PC source (1 = branch target)
//   br, memreg, mr, mw,   datapath enables
//   alusrc, regwr, aluop
//   retire, instret       registered retire pulse and retired count
//   trap, trap_cause      sticky fault flag and cause (01 illegal,
//                         10 imem timeout, 11 dmem timeout)
module multicycle_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             br,
    output logic             memreg,
    output logic             mr,
    output logic             mw,
    output logic             alusrc,
    output logic             regwr,
    output logic [1:0]       aluop,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R  = 7'h33;
    localparam logic [6:0] OP_I  = 7'h13;
    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_ST = 7'h23;
    localparam logic [6:0] OP_BR = 7'h63;

    localparam int          WAIT_W   = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              trap_q, trap_d;
    logic [1:0]        cause_q, cause_d;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LD, OP_ST, OP_BR: is_legal = 1'b1;
            default:                         is_legal = 1'b0;
        endcase
    endfunction

    // Next-state, wait counter, completion and trap capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wait_d   = {WAIT_W{1'b0}};   // cleared outside FETCH/MEM stalls
        retire_d = 1'b0;
        trap_d   = trap_q;
        cause_d  = cause_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
                else     state_d = S_IDLE;
            end
            S_FETCH: begin
                // A ready on the last allowed cycle beats the timeout.
                if (imem_ready) begin
                    op_d    = opcode;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_legal(op_q)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b01;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BR: begin
                        retire_d = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                    OP_LD, OP_ST: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (op_q == OP_ST) begin
                        retire_d = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d  = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b11;
                end else begin
                    wait_d  = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                retire_d = 1'b1;
                state_d  = run ? S_FETCH : S_IDLE;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        instret_d = retire_d ? (instret_q + CNT_W'(1)) : instret_q;
    end

    // State, opcode, counters and sticky trap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 7'h00;
            wait_q    <= {WAIT_W{1'b0}};
            retire_q  <= 1'b0;
            instret_q <= {CNT_W{1'b0}};
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    // Control outputs decoded from state, latched opcode and handshakes.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 1'b0;
        br       = 1'b0;
        memreg   = 1'b0;
        mr       = 1'b0;
        mw       = 1'b0;
        alusrc   = 1'b0;
        regwr    = 1'b0;
        aluop    = 2'b00;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: aluop = 2'b10;
                    OP_I: begin
                        alusrc = 1'b1;
                        aluop  = 2'b10;
                    end
                    OP_LD, OP_ST: alusrc = 1'b1;
                    OP_BR: begin
                        aluop  = 2'b01;
                        br     = 1'b1;
                        pc_src = zero;
                        pc_we  = 1'b1;
                    end
                    default: aluop = 2'b00;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                mr       = (op_q == OP_LD);
                mw       = (op_q == OP_ST);
                pc_we    = (op_q == OP_ST) && dmem_ready;
            end
            S_WB: begin
                regwr  = 1'b1;
                memreg = (op_q == OP_LD);
                pc_we  = 1'b1;
            end
            default: aluop = 2'b00;
        endcase
    end

    assign retire     = retire_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule
